// File: rtl/ifid_stage.sv
// IF/ID stage register: captures the 1-cycle imem fetch with its PC/PC+4,
// adds valid/stall/flush control and a 1-entry skid buffer for stalled fetches.
// Ports: clk, rst (async high); pc_in/sum_in/instr_in/imem_valid from fetch;
//        stall/flush from hazard unit; pc_out/sum_out/instr_out/valid_out to
//        decode; fetch_stall to the PC register; overflow_err sticky drop flag.
module ifid_stage #(
  parameter int          XLEN = 32,
  parameter logic [31:0] NOP  = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] sum_in,
  input  logic [XLEN-1:0] instr_in,
  input  logic            imem_valid,
  input  logic            stall,
  input  logic            flush,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] sum_out,
  output logic [XLEN-1:0] instr_out,
  output logic            valid_out,
  output logic            fetch_stall,
  output logic            overflow_err
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] instr;
  } beat_t;

  localparam logic [XLEN-1:0] NOP_W = XLEN'(NOP);

  beat_t in_b;
  beat_t out_q, out_n;
  beat_t skid_q, skid_n;
  logic  valid_q, valid_n;
  logic  skid_valid, skid_valid_n;
  logic  ovf_q, ovf_n;

  assign in_b = '{pc: pc_in, sum: sum_in, instr: instr_in};

  // Priority flush > stall > drain skid > advance; the case
  // items are made mutually exclusive so the decoder is one-hot.
  always_comb begin
    out_n        = out_q;
    skid_n       = skid_q;
    valid_n      = valid_q;
    skid_valid_n = skid_valid;
    ovf_n        = ovf_q;
    unique case (1'b1)
      flush: begin
        valid_n      = 1'b0;
        out_n.instr  = NOP_W;
        skid_valid_n = 1'b0;
      end
      (!flush && stall): begin
        if (imem_valid) begin
          if (!skid_valid) begin
            skid_n       = in_b;
            skid_valid_n = 1'b1;
          end else begin
            ovf_n = 1'b1;
          end
        end
      end
      (!flush && !stall && skid_valid): begin
        // Skidded beat leaves first to keep program order.
        out_n   = skid_q;
        valid_n = 1'b1;
        if (imem_valid) begin
          skid_n = in_b;
        end else begin
          skid_valid_n = 1'b0;
        end
      end
      default: begin
        if (imem_valid) begin
          out_n   = in_b;
          valid_n = 1'b1;
        end else begin
          valid_n     = 1'b0;
          out_n.instr = NOP_W;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '{pc: '0, sum: '0, instr: NOP_W};
      skid_q     <= '0;
      valid_q    <= 1'b0;
      skid_valid <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      out_q      <= out_n;
      skid_q     <= skid_n;
      valid_q    <= valid_n;
      skid_valid <= skid_valid_n;
      ovf_q      <= ovf_n;
    end
  end

  assign pc_out       = out_q.pc;
  assign sum_out      = out_q.sum;
  assign instr_out    = out_q.instr;
  assign valid_out    = valid_q;
  assign fetch_stall  = stall | skid_valid;
  assign overflow_err = ovf_q;

endmodule

// File: doc/ifid_stage.md
Name: ifid_stage

Overview:
- IF/ID pipeline register that feeds the decode stage and the ID/EX register.
- Captures the instruction returned by the 1-cycle-latency instruction memory together with its PC and PC+4.
- Adds the valid/stall/flush control the other stage registers lack, plus a 1-entry skid buffer that catches the in-flight fetch while decode is stalled.
- Drives fetch_stall back to the PC register.

Parameters:
- XLEN, 32, datapath width of pc/sum/instr.
- NOP, 32'h00000013, instruction word presented on instr_out when the stage holds a bubble (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- pc_in  input  XLEN  PC of the fetch returning this cycle.
- sum_in  input  XLEN  PC+4 of the same fetch.
- instr_in  input  XLEN  instruction word from instruction memory.
- imem_valid  input  1  instr_in/pc_in/sum_in carry a real fetch this cycle.
- stall  input  1  hazard unit: hold the ID-stage contents.
- flush  input  1  taken branch/jump resolved in EX: kill the ID contents and the in-flight fetch.
- pc_out  output  XLEN  registered PC to decode.
- sum_out  output  XLEN  registered PC+4 to decode.
- instr_out  output  XLEN  registered instruction to decode.
- valid_out  output  1  instr_out is a real instruction; when 0, decode must force we/store to 0.
- fetch_stall  output  1  combinational: stall | skid_valid. PC must hold, with no new imem request, while it is high.
- overflow_err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (async, rst=1):
  - valid_out=0, instr_out=NOP, pc_out=0, sum_out=0.
  - Skid buffer emptied (skid_valid=0).
  - overflow_err=0.
  - Takes effect immediately and mid-operation; fetches in flight are lost.
- States, encoded by {valid_out, skid_valid}:
  - EMPTY: {0,0}.
  - RUN: {1,0}.
  - SKID: {x,1}.
- Priority at each rising edge: flush > stall > advance.
- flush=1:
  - valid_out<=0, instr_out<=NOP, skid_valid<=0.
  - Any imem_valid beat in the same cycle is discarded.
  - pc_out/sum_out are don't-care; they hold.
  - Next state EMPTY, regardless of stall.
- stall=1, flush=0:
  - Output registers hold.
  - If imem_valid=1 and skid empty: skid <= {pc_in, sum_in, instr_in}, skid_valid<=1 (-> SKID).
  - If imem_valid=1 and skid full: beat dropped, overflow_err<=1.
- stall=0, flush=0, skid full:
  - Outputs <= skid contents, valid_out<=1.
  - If imem_valid=1: skid <= incoming beat and stays full (imem should not deliver here; the beat is still accepted without error).
  - Otherwise skid_valid<=0 (-> RUN).
- stall=0, flush=0, skid empty:
  - If imem_valid=1: outputs <= incoming beat, valid_out<=1.
  - Else: valid_out<=0, instr_out<=NOP (bubble, -> EMPTY).
- Latency: 1 cycle from imem_valid to valid_out when not stalled. A skidded beat presents 1 cycle after stall falls.
- Ordering: program order is preserved. A skidded instruction always leaves before any later fetch.
- fetch_stall is combinational from stall and skid_valid. With 1-cycle imem, at most one beat arrives after fetch_stall rises, so the skid never overflows under correct protocol.
- overflow_err: set only by a drop. Cleared only by rst; flush does not clear it.

Test Plan:
- Reset: hold rst with imem_valid=1, instr_in=0x00500093 -> valid_out=0, instr_out=0x00000013, fetch_stall=0. Release rst; next edge -> instr_out=0x00500093, valid_out=1.
- Stream: 4 consecutive beats, PCs 0x0,0x4,0x8,0xC -> pc_out follows 1 cycle later each cycle; sum_out=pc_out+4; no bubbles.
- Stall with in-flight beat:
  - Stimulus: ID holds PC 0x8; stall=1 for 3 cycles; beat PC 0xC arrives in the first stall cycle.
  - Required: skid_valid=1 and fetch_stall=1 throughout; pc_out stays 0x8.
  - Required: 1 cycle after stall falls, pc_out=0xC. Next cycle, the new beat PC 0x10 appears; no loss, no duplicate.
- Flush while skid full: SKID state, flush=1 together with stall=1 -> next edge valid_out=0, instr_out=NOP, fetch_stall=0 (stall dropped), skid empty. Beat PC 0x40 next cycle -> valid_out=1, pc_out=0x40.
- Bubble: stall=0, imem_valid=0 for one cycle mid-stream -> valid_out=0 and instr_out=NOP for exactly one cycle, then resumes.
- Overflow: skid full, stall=1, imem_valid=1 -> overflow_err=1 and stays 1 after stall/flush; skid keeps the original beat; only rst clears the flag.
